// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types for the pipeline controller (FSM states, stage-enable bundle, presets).
// Latency: n/a (types and constants only).
// Backpressure: n/a; the presets encode freeze/bubble/redirect patterns used by pipeline_ctrl.
package pipe_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Stage register write enables plus bubble-insert controls.
    typedef struct packed {
        logic pc_write;
        logic ifde_write;
        logic deex_write;
        logic exmem_write;
        logic memwb_write;
        logic ifde_flush;
        logic deex_flush;
    } ctl_t;

    // Whole pipeline holds.
    localparam ctl_t CTL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Everything advances.
    localparam ctl_t CTL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    // Taken control transfer: PC takes the target, younger stages squashed.
    localparam ctl_t CTL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // Front end holds, bubble enters EX, back end drains.
    localparam ctl_t CTL_BUBBLE   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    // Late-arriving wrong-path fetch is dropped; PC already holds the target.
    localparam ctl_t CTL_DISCARD  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Purpose: saturating event counter with synchronous clear. Ports: clk_i, rst_i, inc_i, clr_i, cnt_o.
// Latency: one cycle from inc_i/clr_i to cnt_o.
// Backpressure: none; holds at all-ones, clear overrides a same-cycle increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Purpose: 5-stage pipeline stall/flush/halt controller with stall and flush counters.
// Latency: enables/flushes combinational (0 cycles); halt_ack_o and counters registered (1 cycle).
// Backpressure: dmem_busy_i freezes all stages; imem_busy_i/load_use_haz_i bubble EX; halt freezes.
// Ports: hazard/busy/debug inputs (_i); five stage write enables, two flushes, halt_ack_o, counters (_o).
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_use_haz_i,
    input  logic             control_haz_i,
    input  logic             imem_busy_i,
    input  logic             dmem_busy_i,
    input  logic             halt_req_i,
    input  logic             step_i,
    input  logic             clr_cnt_i,
    output logic             pc_write_o,
    output logic             ifde_write_o,
    output logic             deex_write_o,
    output logic             exmem_write_o,
    output logic             memwb_write_o,
    output logic             ifde_flush_o,
    output logic             deex_flush_o,
    output logic             halt_ack_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e state_q;
    state_e state_d;
    logic   halt_ack_q;
    ctl_t   ctl;
    logic   stall_inc;
    logic   flush_inc;

    always_comb begin
        ctl       = CTL_FREEZE;
        state_d   = state_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (dmem_busy_i) begin
                    stall_inc = 1'b1;
                end else if (control_haz_i) begin
                    ctl       = CTL_REDIRECT;
                    flush_inc = 1'b1;
                    // Fetch of the target may still be in flight; its stale word must be dropped.
                    state_d   = imem_busy_i ? ST_SQUASH : ST_RUN;
                end else if (halt_req_i && !imem_busy_i) begin
                    // Halt entry freezes but is not counted as a stall.
                    state_d = ST_HALTED;
                end else if (load_use_haz_i || imem_busy_i) begin
                    ctl       = CTL_BUBBLE;
                    stall_inc = 1'b1;
                end else begin
                    ctl = CTL_NORMAL;
                end
            end
            ST_SQUASH: begin
                if (dmem_busy_i) begin
                    stall_inc = 1'b1;
                end else if (imem_busy_i) begin
                    ctl       = CTL_BUBBLE;
                    stall_inc = 1'b1;
                end else begin
                    ctl       = CTL_DISCARD;
                    stall_inc = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (step_i && !imem_busy_i && !dmem_busy_i) begin
                    // One RUN decision without the halt term; stays halted afterwards.
                    if (control_haz_i) begin
                        ctl       = CTL_REDIRECT;
                        flush_inc = 1'b1;
                    end else if (load_use_haz_i) begin
                        ctl = CTL_BUBBLE;
                    end else begin
                        ctl = CTL_NORMAL;
                    end
                end else if (!halt_req_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (rst_i) begin
            ctl       = CTL_FREEZE;
            stall_inc = 1'b0;
            flush_inc = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            halt_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_ack_q <= (state_d == ST_HALTED);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .clr_i (clr_cnt_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .clr_i (clr_cnt_i),
        .cnt_o (flush_cnt_o)
    );

    assign pc_write_o    = ctl.pc_write;
    assign ifde_write_o  = ctl.ifde_write;
    assign deex_write_o  = ctl.deex_write;
    assign exmem_write_o = ctl.exmem_write;
    assign memwb_write_o = ctl.memwb_write;
    assign ifde_flush_o  = ctl.ifde_flush;
    assign deex_flush_o  = ctl.deex_flush;
    assign halt_ack_o    = halt_ack_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Purpose: directed scoreboard bench for pipeline_ctrl (CNT_W=4 so saturation is reachable).
// Latency: vectors driven 1ns after posedge, outputs sampled on the following negedge.
// Backpressure: n/a; one expected entry per driven vector.
module tb_pipeline_ctrl;

    localparam int W = 4;

    // Input vector bits: {rst, dmem, ctrl, halt, lu, imem, step, clr}
    localparam logic [7:0] I_RST  = 8'h80;
    localparam logic [7:0] I_DMEM = 8'h40;
    localparam logic [7:0] I_CTRL = 8'h20;
    localparam logic [7:0] I_HALT = 8'h10;
    localparam logic [7:0] I_LU   = 8'h08;
    localparam logic [7:0] I_IMEM = 8'h04;
    localparam logic [7:0] I_STEP = 8'h02;
    localparam logic [7:0] I_CLR  = 8'h01;

    // Expected enables: {pc, ifde, deex, exmem, memwb, ifde_flush, deex_flush}
    localparam logic [6:0] E_FRZ  = 7'b00000_00;
    localparam logic [6:0] E_NORM = 7'b11111_00;
    localparam logic [6:0] E_CTRL = 7'b11111_11;
    localparam logic [6:0] E_BUB  = 7'b00111_01;
    localparam logic [6:0] E_DISC = 7'b01111_11;

    typedef struct packed {
        logic [6:0]   en;
        logic         ack;
        logic [W-1:0] sc;
        logic [W-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i, load_use_haz_i, control_haz_i, imem_busy_i, dmem_busy_i;
    logic halt_req_i, step_i, clr_cnt_i;
    logic pc_write_o, ifde_write_o, deex_write_o, exmem_write_o, memwb_write_o;
    logic ifde_flush_o, deex_flush_o, halt_ack_o;
    logic [W-1:0] stall_cnt_o, flush_cnt_o;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;
    bit    stim_done = 1'b0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .load_use_haz_i (load_use_haz_i),
        .control_haz_i  (control_haz_i),
        .imem_busy_i    (imem_busy_i),
        .dmem_busy_i    (dmem_busy_i),
        .halt_req_i     (halt_req_i),
        .step_i         (step_i),
        .clr_cnt_i      (clr_cnt_i),
        .pc_write_o     (pc_write_o),
        .ifde_write_o   (ifde_write_o),
        .deex_write_o   (deex_write_o),
        .exmem_write_o  (exmem_write_o),
        .memwb_write_o  (memwb_write_o),
        .ifde_flush_o   (ifde_flush_o),
        .deex_flush_o   (deex_flush_o),
        .halt_ack_o     (halt_ack_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    task automatic drive(input logic [7:0] in);
        rst_i          = in[7];
        dmem_busy_i    = in[6];
        control_haz_i  = in[5];
        halt_req_i     = in[4];
        load_use_haz_i = in[3];
        imem_busy_i    = in[2];
        step_i         = in[1];
        clr_cnt_i      = in[0];
    endtask

    // One clock cycle of stimulus with its hand-computed expected response.
    task automatic v(input string nm, input logic [7:0] in, input logic [6:0] en,
                     input logic ack, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        drive(in);
        e.en  = en;
        e.ack = ack;
        e.sc  = W'(sc);
        e.fc  = W'(fc);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: every cycle the DUT presents a response for the vector in flight.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.en  = {pc_write_o, ifde_write_o, deex_write_o, exmem_write_o, memwb_write_o,
                     ifde_flush_o, deex_flush_o};
            a.ack = halt_ack_o;
            a.sc  = stall_cnt_o;
            a.fc  = flush_cnt_o;
            n_vec = n_vec + 1;
            if (a !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got en=%b ack=%b stall=%0d flush=%0d, want en=%b ack=%b stall=%0d flush=%0d",
                         nm, a.en, a.ack, a.sc, a.fc, e.en, e.ack, e.sc, e.fc);
            end
        end
    end

    initial begin
        drive(I_RST);
        repeat (2) @(posedge clk);

        v("reset",          I_RST,          E_FRZ,  0, 0, 0);
        v("normal",         8'h00,          E_NORM, 0, 0, 0);
        v("load_use",       I_LU,           E_BUB,  0, 0, 0);
        v("after_lu",       8'h00,          E_NORM, 0, 1, 0);
        v("imem_busy",      I_IMEM,         E_BUB,  0, 1, 0);
        // Redirect with fetch outstanding, then two squash stalls, then discard.
        v("ctrl_imem",      I_CTRL|I_IMEM,  E_CTRL, 0, 2, 0);
        v("squash1",        I_CTRL|I_IMEM,  E_BUB,  0, 2, 1);
        v("squash2",        I_CTRL|I_IMEM,  E_BUB,  0, 3, 1);
        v("discard",        8'h00,          E_DISC, 0, 4, 1);
        v("run_after_sq",   8'h00,          E_NORM, 0, 5, 1);
        // dmem_busy outranks everything.
        v("dmem_prio1",     I_DMEM|I_CTRL|I_LU, E_FRZ, 0, 5, 1);
        v("dmem_prio2",     I_DMEM|I_CTRL|I_LU, E_FRZ, 0, 6, 1);
        v("ctrl_after_dm",  I_CTRL|I_LU,    E_CTRL, 0, 7, 1);
        // Halt outranks load-use; halt entry not counted.
        v("halt_entry",     I_HALT|I_LU,    E_FRZ,  0, 7, 2);
        v("halted",         I_HALT,         E_FRZ,  1, 7, 2);
        v("step",           I_HALT|I_STEP,  E_NORM, 1, 7, 2);
        v("halted2",        I_HALT,         E_FRZ,  1, 7, 2);
        v("step_busy",      I_HALT|I_STEP|I_IMEM, E_FRZ, 1, 7, 2);
        v("step_ctrl",      I_HALT|I_STEP|I_CTRL, E_CTRL, 1, 7, 2);
        v("release",        8'h00,          E_FRZ,  1, 7, 3);
        v("run_again",      8'h00,          E_NORM, 0, 7, 3);
        v("halt_imem",      I_HALT|I_IMEM,  E_BUB,  0, 7, 3);
        v("clr_over_inc",   I_CLR|I_LU,     E_BUB,  0, 8, 3);
        // 20 stall cycles saturate a 4-bit counter at 15.
        for (int i = 0; i < 20; i++) begin
            v("stall_sat",  I_LU,           E_BUB,  0, (i > 15) ? 15 : i, 0);
        end
        v("saturated",      8'h00,          E_NORM, 0, 15, 0);
        v("clr_with_stall", I_CLR|I_LU,     E_BUB,  0, 15, 0);
        v("cleared",        8'h00,          E_NORM, 0, 0, 0);
        // Reset while in SQUASH.
        v("sq_enter",       I_CTRL|I_IMEM,  E_CTRL, 0, 0, 0);
        v("sq_stall",       I_IMEM,         E_BUB,  0, 0, 1);
        v("rst_in_squash",  I_RST|I_IMEM,   E_FRZ,  0, 1, 1);
        v("run_after_rst",  8'h00,          E_NORM, 0, 0, 0);
        // Reset while HALTED.
        v("halt_again",     I_HALT,         E_FRZ,  0, 0, 0);
        v("rst_in_halted",  I_RST|I_HALT,   E_FRZ,  1, 0, 0);
        v("run_after_rst2", 8'h00,          E_NORM, 0, 0, 0);

        @(posedge clk);
        drive(8'h00);
        repeat (3) @(posedge clk);
        stim_done = 1'b1;
    end

    initial begin
        fork
            wait (stim_done);
            #100000;
        join_any
        disable fork;
        if (!stim_done) begin
            n_fail = n_fail + 1;
            $display("FAIL timeout: stimulus incomplete, want completion within 100000ns");
        end
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expected responses unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
